// File: rtl/color_centroid.sv
// rtl/color_centroid.sv - centroid of colour-matched pixels per frame via restoring divide
module color_centroid #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [11:0] R_MIN      = 12'd2048,
    parameter logic [11:0] G_MAX      = 12'd1024,
    parameter logic [11:0] B_MAX      = 12'd1024,
    parameter int          MIN_PIXELS = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [11:0] iRed,
    input  logic [11:0] iGreen,
    input  logic [11:0] iBlue,
    input  logic [10:0] iX_Cont,
    input  logic [10:0] iY_Cont,
    output logic [10:0] oRow,
    output logic [10:0] oCol,
    output logic        oDVAL,
    output logic        oBusy,
    output logic        oDrop
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t      r_state;
    logic [18:0] r_cnt, r_lat_cnt, r_div;
    logic [27:0] r_sum_x, r_sum_y, r_lat_sx, r_lat_sy;
    logic [27:0] r_quo_x, r_quo_y;
    logic [18:0] r_rem_x, r_rem_y;
    logic [4:0]  r_iter;
    logic        r_eof_d, r_eof_ovr;

    logic        w_match, w_eof, w_start, w_drop;
    logic [18:0] w_cnt_nx;
    logic [27:0] w_sx_nx, w_sy_nx;
    logic [19:0] w_trial_x, w_trial_y, w_diff_x, w_diff_y;
    logic        w_ge_x, w_ge_y;

    assign w_match  = iDVAL && (iRed >= R_MIN) && (iGreen <= G_MAX) && (iBlue <= B_MAX);
    assign w_eof    = iDVAL && (iX_Cont == 11'(H_ACTIVE - 1)) && (iY_Cont == 11'(V_ACTIVE - 1));
    assign w_cnt_nx = r_cnt + {18'd0, w_match};
    assign w_sx_nx  = r_sum_x + (w_match ? {17'd0, iX_Cont} : 28'd0);
    assign w_sy_nx  = r_sum_y + (w_match ? {17'd0, iY_Cont} : 28'd0);

    // The frame decision is made one edge after EOF, from the latched totals.
    assign w_start = r_eof_d && !r_eof_ovr && (r_state == S_IDLE) && (r_lat_cnt >= 19'(MIN_PIXELS));
    assign w_drop  = r_eof_d && !w_start;

    assign w_trial_x = {r_rem_x, r_quo_x[27]};
    assign w_trial_y = {r_rem_y, r_quo_y[27]};
    assign w_ge_x    = w_trial_x >= {1'b0, r_div};
    assign w_ge_y    = w_trial_y >= {1'b0, r_div};
    assign w_diff_x  = w_trial_x - {1'b0, r_div};
    assign w_diff_y  = w_trial_y - {1'b0, r_div};

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_cnt     <= '0;
            r_sum_x   <= '0;
            r_sum_y   <= '0;
            r_lat_cnt <= '0;
            r_lat_sx  <= '0;
            r_lat_sy  <= '0;
            r_eof_d   <= 1'b0;
            r_eof_ovr <= 1'b0;
        end else begin
            r_eof_d <= w_eof;
            if (w_eof) begin
                r_lat_cnt <= w_cnt_nx;
                r_lat_sx  <= w_sx_nx;
                r_lat_sy  <= w_sy_nx;
                r_eof_ovr <= (r_state != S_IDLE);
                r_cnt     <= '0;
                r_sum_x   <= '0;
                r_sum_y   <= '0;
            end else begin
                r_cnt   <= w_cnt_nx;
                r_sum_x <= w_sx_nx;
                r_sum_y <= w_sy_nx;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_quo_x <= '0;
            r_quo_y <= '0;
            r_rem_x <= '0;
            r_rem_y <= '0;
            r_iter  <= '0;
            oRow    <= '0;
            oCol    <= '0;
            oDVAL   <= 1'b0;
            oBusy   <= 1'b0;
            oDrop   <= 1'b0;
        end else begin
            oDVAL <= 1'b0;
            oDrop <= w_drop;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_DIV;
                        oBusy   <= 1'b1;
                        r_div   <= r_lat_cnt;
                        r_quo_x <= r_lat_sx;
                        r_quo_y <= r_lat_sy;
                        r_rem_x <= '0;
                        r_rem_y <= '0;
                        r_iter  <= '0;
                    end
                end
                S_DIV: begin
                    // Dividend bits shift out of r_quo_* as quotient bits shift in.
                    r_rem_x <= w_ge_x ? w_diff_x[18:0] : w_trial_x[18:0];
                    r_rem_y <= w_ge_y ? w_diff_y[18:0] : w_trial_y[18:0];
                    r_quo_x <= {r_quo_x[26:0], w_ge_x};
                    r_quo_y <= {r_quo_y[26:0], w_ge_y};
                    r_iter  <= r_iter + 5'd1;
                    if (r_iter == 5'd27) r_state <= S_DONE;
                end
                S_DONE: begin
                    oCol    <= r_quo_x[10:0];
                    oRow    <= r_quo_y[10:0];
                    oDVAL   <= 1'b1;
                    oBusy   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_color_centroid.sv
// tb/tb_color_centroid.sv - directed self-checking bench for color_centroid
module tb_color_centroid;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iDVAL = 1'b0;
    logic [11:0] iRed = '0, iGreen = '0, iBlue = '0;
    logic [10:0] iX_Cont = '0, iY_Cont = '0;
    logic [10:0] oRow, oCol, oRow1, oCol1;
    logic        oDVAL, oBusy, oDrop, oDVAL1, oBusy1, oDrop1;

    int n_checks = 0;
    int n_errors = 0;

    int dv_k0, dv_n0, busy_n0, drop_k0, drop_n0, dv_k1, dv_n1;
    logic [10:0] cap_col0, cap_row0, cap_col1, cap_row1;

    always #5 iCLK = ~iCLK;

    color_centroid u_dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .oRow(oRow), .oCol(oCol), .oDVAL(oDVAL), .oBusy(oBusy), .oDrop(oDrop)
    );

    color_centroid #(.MIN_PIXELS(1)) u_dut1 (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .oRow(oRow1), .oCol(oCol1), .oDVAL(oDVAL1), .oBusy(oBusy1), .oDrop(oDrop1)
    );

    task automatic pix(input logic dv, input int px, input int py, input logic red_on);
        iDVAL   = dv;
        iX_Cont = 11'(px);
        iY_Cont = 11'(py);
        iRed    = red_on ? 12'd3000 : 12'd0;
        iGreen  = red_on ? 12'd200 : 12'd0;
        iBlue   = red_on ? 12'd100 : 12'd0;
        @(posedge iCLK);
        #1;
    endtask

    // Square at cols 100-107, lines 200-207; ends with the EOF pixel.
    task automatic send_square(input bit gaps, input bit drop_one);
        pix(1'b1, 0, 0, 1'b0);
        pix(1'b1, 10, 150, 1'b0);
        for (int y = 200; y < 208; y++) begin
            for (int x = 100; x < 108; x++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 3)) begin
                        if ($urandom_range(0, 1) == 1) pix(1'b0, 639, 479, 1'b1);
                        else pix(1'b0, $urandom_range(0, 600), $urandom_range(0, 400), 1'b1);
                    end
                end
                pix(1'b1, x, y, !(drop_one && x == 107 && y == 207));
            end
        end
        pix(1'b1, 639, 479, 1'b0);
    endtask

    task automatic watch(input int eof_at, input int rst_at);
        dv_k0 = -1; dv_n0 = 0; busy_n0 = 0; drop_k0 = -1; drop_n0 = 0;
        dv_k1 = -1; dv_n1 = 0;
        for (int k = 1; k <= 40; k++) begin
            iDVAL = (k == eof_at); iX_Cont = 11'd639; iY_Cont = 11'd479;
            iRed = '0; iGreen = '0; iBlue = '0;
            if (k == rst_at) iRST = 1'b0;
            if (rst_at > 0 && k == rst_at + 3) iRST = 1'b1;
            @(posedge iCLK);
            #1;
            if (oDVAL) begin
                dv_n0++;
                if (dv_k0 < 0) dv_k0 = k;
                cap_col0 = oCol; cap_row0 = oRow;
            end
            if (oBusy) busy_n0++;
            if (oDrop) begin
                drop_n0++;
                if (drop_k0 < 0) drop_k0 = k;
            end
            if (oDVAL1) begin
                dv_n1++;
                if (dv_k1 < 0) dv_k1 = k;
                cap_col1 = oCol1; cap_row1 = oRow1;
            end
        end
    endtask

    task automatic test_reset;
        iRST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iDVAL = 1'($urandom_range(0, 1));
            iRed = 12'($urandom); iGreen = 12'($urandom); iBlue = 12'($urandom);
            iX_Cont = 11'($urandom_range(0, 639)); iY_Cont = 11'($urandom_range(0, 479));
            @(posedge iCLK);
            #1;
            n_checks++;
            if ({oRow, oCol, oDVAL, oBusy, oDrop} !== 25'd0) begin
                n_errors++;
                $display("FAIL reset_hold cycle %0d: got %h expected 0", i, {oRow, oCol, oDVAL, oBusy, oDrop});
            end
        end
        iDVAL = 1'b0;
        iRST  = 1'b1;
        @(posedge iCLK);
        #1;
        n_checks++;
        if ({oRow, oCol, oDVAL, oBusy, oDrop} !== 25'd0) begin
            n_errors++;
            $display("FAIL reset_release: got %h expected 0", {oRow, oCol, oDVAL, oBusy, oDrop});
        end
    endtask

    task automatic test_square;
        send_square(1'b0, 1'b0);
        watch(0, 0);
        n_checks++;
        if (dv_k0 != 30 || dv_n0 != 1) begin
            n_errors++;
            $display("FAIL square_dval: at %0d count %0d expected at 30 count 1", dv_k0, dv_n0);
        end
        n_checks++;
        if (cap_col0 !== 11'd103 || cap_row0 !== 11'd203) begin
            n_errors++;
            $display("FAIL square_result: col %0d row %0d expected 103 203", cap_col0, cap_row0);
        end
        n_checks++;
        if (busy_n0 != 29) begin
            n_errors++;
            $display("FAIL square_busy: %0d cycles expected 29", busy_n0);
        end
        n_checks++;
        if (drop_n0 != 0) begin
            n_errors++;
            $display("FAIL square_drop: %0d pulses expected 0", drop_n0);
        end
    endtask

    task automatic test_below_min;
        send_square(1'b0, 1'b1);
        watch(0, 0);
        n_checks++;
        if (drop_k0 != 1 || drop_n0 != 1) begin
            n_errors++;
            $display("FAIL below_min_drop: at %0d count %0d expected at 1 count 1", drop_k0, drop_n0);
        end
        n_checks++;
        if (dv_n0 != 0) begin
            n_errors++;
            $display("FAIL below_min_dval: %0d pulses expected 0", dv_n0);
        end
        n_checks++;
        if (oCol !== 11'd103 || oRow !== 11'd203) begin
            n_errors++;
            $display("FAIL below_min_hold: col %0d row %0d expected 103 203", oCol, oRow);
        end
    endtask

    task automatic test_gapped;
        send_square(1'b1, 1'b0);
        watch(0, 0);
        n_checks++;
        if (dv_k0 != 30 || cap_col0 !== 11'd103 || cap_row0 !== 11'd203) begin
            n_errors++;
            $display("FAIL gapped: at %0d col %0d row %0d expected at 30 col 103 row 203", dv_k0, cap_col0, cap_row0);
        end
    endtask

    task automatic test_single_pixel;
        pix(1'b1, 639, 479, 1'b1);
        watch(0, 0);
        n_checks++;
        if (dv_k1 != 30 || cap_col1 !== 11'd639 || cap_row1 !== 11'd479) begin
            n_errors++;
            $display("FAIL single_pixel: at %0d col %0d row %0d expected at 30 col 639 row 479", dv_k1, cap_col1, cap_row1);
        end
        n_checks++;
        if (drop_n0 != 1 || dv_n0 != 0 || oCol !== 11'd103) begin
            n_errors++;
            $display("FAIL single_pixel_min64: drops %0d dvals %0d col %0d expected 1 0 103", drop_n0, dv_n0, oCol);
        end
    endtask

    task automatic test_overrun;
        send_square(1'b0, 1'b0);
        watch(5, 0);
        n_checks++;
        if (drop_n0 != 1 || drop_k0 != 6) begin
            n_errors++;
            $display("FAIL overrun_drop: count %0d at %0d expected count 1 at 6", drop_n0, drop_k0);
        end
        n_checks++;
        if (dv_n0 != 1 || dv_k0 != 30 || cap_col0 !== 11'd103 || cap_row0 !== 11'd203) begin
            n_errors++;
            $display("FAIL overrun_result: n %0d at %0d col %0d row %0d expected 1 30 103 203", dv_n0, dv_k0, cap_col0, cap_row0);
        end
    endtask

    task automatic test_mid_reset;
        send_square(1'b0, 1'b0);
        watch(0, 10);
        n_checks++;
        if (dv_n0 != 0 || oBusy !== 1'b0 || oCol !== 11'd0 || oRow !== 11'd0) begin
            n_errors++;
            $display("FAIL mid_reset_abort: dvals %0d busy %b col %0d row %0d expected 0 0 0 0", dv_n0, oBusy, oCol, oRow);
        end
        send_square(1'b0, 1'b0);
        watch(0, 0);
        n_checks++;
        if (dv_k0 != 30 || cap_col0 !== 11'd103 || cap_row0 !== 11'd203) begin
            n_errors++;
            $display("FAIL mid_reset_next: at %0d col %0d row %0d expected at 30 col 103 row 203", dv_k0, cap_col0, cap_row0);
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_below_min();
        test_gapped();
        test_single_pixel();
        test_overrun();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/color_centroid.md
COLOR_CENTROID -- requirements
Module: color_centroid

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL provide parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL provide parameters R_MIN 12'd2048, G_MAX 12'd1024, B_MAX 12'd1024, the colour-match thresholds.
REQ-004 SHALL provide parameter MIN_PIXELS, default 64, minimum matched count for a valid result; legal range is 1 or more.
REQ-005 iCLK  input  1  single clock; all logic SHALL be clocked on the rising edge.
REQ-006 iRST  input  1  reset, asynchronous and active-low; the only reset in the block.
REQ-007 iDVAL  input  1  pixel valid strobe.
REQ-008 iRed, iGreen, iBlue  input  12 each  pixel colour components.
REQ-009 iX_Cont, iY_Cont  input  11 each  column and line of the current pixel.
REQ-010 oRow  output  11  centroid line, registered.
REQ-011 oCol  output  11  centroid column, registered.
REQ-012 oDVAL  output  1  single-cycle result strobe.
REQ-013 oBusy  output  1  high while the divider is running.
REQ-014 oDrop  output  1  single-cycle pulse when a frame result is discarded.

Function
REQ-015 A pixel SHALL match when all of the following hold on the same edge: iDVAL=1, iRed>=R_MIN, iGreen<=G_MAX, iBlue<=B_MAX.
REQ-016 Each matched pixel SHALL add 1 to cnt (19b), iX_Cont to sum_x (28b) and iY_Cont to sum_y (28b); no saturation is needed because the bounds are 640*480.
REQ-017 End of frame (EOF) SHALL be the edge sampling iDVAL=1 with iX_Cont=H_ACTIVE-1 and iY_Cont=V_ACTIVE-1.
REQ-018 On EOF the block SHALL latch cnt, sum_x and sum_y, including that pixel's own contribution, and clear the accumulators, so the next edge starts a fresh frame.
REQ-019 The block SHALL implement FSM IDLE -> DIV -> DONE -> IDLE.
REQ-020 IDLE->DIV SHALL occur on EOF when the latched cnt>=MIN_PIXELS.
REQ-021 When the latched cnt<MIN_PIXELS at EOF, the FSM SHALL stay in IDLE, pulse oDrop for one cycle and leave oRow/oCol unchanged.
REQ-022 DIV SHALL run a restoring divider of exactly 28 iterations, one quotient bit per cycle, computing sum_x/cnt and sum_y/cnt in parallel; quotients are floor values.
REQ-023 DIV->DONE SHALL occur after the 28th iteration; in DONE, oCol and oRow SHALL load quotient[10:0] and oDVAL SHALL pulse for one cycle.
REQ-024 DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-025 oDVAL SHALL rise exactly 30 edges after the EOF edge.
REQ-026 oBusy SHALL be high in DIV and DONE.
REQ-027 EOF while oBusy=1 SHALL leave the running division untouched, still clear the accumulators, discard the new frame and pulse oDrop.
REQ-028 Accumulation SHALL continue independently of FSM state.
REQ-029 iDVAL=0 cycles, including arbitrary gaps, SHALL have no effect on any accumulator.
REQ-030 oRow and oCol SHALL hold their last result until the next DONE.

Reset
REQ-031 While iRST=0, the block SHALL hold FSM=IDLE; oRow=0, oCol=0, oDVAL=0, oBusy=0, oDrop=0; all accumulators, latches and divider registers at 0.
REQ-032 Reset asserted mid-DIV SHALL abort the division with no oDVAL.
REQ-033 The first frame after reset release SHALL accumulate from zero; a partial frame in progress at release is counted from the release point.

Verification
REQ-034 Reset check: hold iRST=0 for 5 cycles with random pixels -> all outputs 0 throughout and 0 on the first cycle after release.
REQ-035 Square frame: red 8x8 square at cols 100-107, lines 200-207, background black -> oDVAL exactly 30 cycles after EOF, oCol=103, oRow=203; oBusy high for 29 cycles.
REQ-036 Below minimum: same frame with 63 matched pixels -> oDrop pulses on the EOF+1 edge, no oDVAL, oRow/oCol keep their prior values.
REQ-037 Gapped stream: square frame from REQ-035 with random iDVAL=0 gaps, plus the single-pixel case: MIN_PIXELS=1, only pixel (639,479) matched -> identical result to REQ-035 for the gapped frame, and oCol=639, oRow=479 for the single pixel.
REQ-038 Mid-divide reset: pulse iRST low 10 cycles after EOF, then send the square frame again -> no oDVAL from the aborted frame; the next frame gives oCol=103, oRow=203.
REQ-039 Overrun: force a second EOF 5 cycles after the first, using a shrunk V_ACTIVE/H_ACTIVE bench -> oDrop pulses once; the first result completes unchanged.
